// File: rtl/div_ratio_sequencer_pkg.sv
// Shared definitions for the divided-clock ratio sequencer: selection encoding,
// ratio lookup, controller state type and the auto-cycling step order.
package div_ratio_sequencer_pkg;

  localparam logic [1:0] SEL_DIV3 = 2'd0;
  localparam logic [1:0] SEL_DIV2 = 2'd1;
  localparam logic [1:0] SEL_DIV4 = 2'd2;
  localparam logic [1:0] SEL_DIV8 = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } seq_state_e;

  function automatic logic [3:0] sel_to_ratio(input logic [1:0] sel);
    logic [3:0] ratio;
    case (sel)
      SEL_DIV3: ratio = 4'd3;
      SEL_DIV2: ratio = 4'd2;
      SEL_DIV4: ratio = 4'd4;
      SEL_DIV8: ratio = 4'd8;
      default:  ratio = 4'd2;
    endcase
    return ratio;
  endfunction

  // Auto mode walks 0 -> 1 -> 2 -> 3 -> 0, which is plain modulo-4 increment.
  function automatic logic [1:0] next_auto_sel(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/div_ratio_sequencer_counter.sv
// div_period_counter: the single divide counter. Counts 0..ratio-1 and decodes
// dclk / period_end purely from its own register and the registered ratio.
module div_period_counter
  import div_ratio_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ratio_i,
  input  logic       load_zero_i,
  output logic [2:0] cnt_o,
  output logic       dclk_o,
  output logic       period_end_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  assign cnt_o        = cnt_q;
  assign dclk_o       = (cnt_q == 3'd0);
  assign period_end_o = ({1'b0, cnt_q} == (ratio_i - 4'd1));

  // Next count: wrap at the end of a period or on an explicit reload.
  always_comb begin
    cnt_d = cnt_q + 3'd1;
    if (period_end_o || load_zero_i) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_ratio_sequencer.sv
// Divide-ratio sequencer: accepts ratio-change requests or auto-cycles the ratio,
// and applies every change only on a period boundary so no period is cut or stretched.
module div_ratio_sequencer
  import div_ratio_sequencer_pkg::*;
#(
  parameter int         DWELL_W = 8,
  parameter logic [1:0] RST_SEL = 2'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [1:0]         req_sel,
  output logic               req_ready,
  input  logic               auto_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               dclk,
  output logic               period_end,
  output logic [1:0]         cur_sel,
  output logic               switched
);

  seq_state_e         state_q, state_d;
  logic [1:0]         cur_sel_q, cur_sel_d;
  logic [1:0]         pend_sel_q, pend_sel_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               switched_q, switched_d;

  logic [3:0]         ratio_s;
  logic [2:0]         cnt_s;
  logic               period_end_s;
  logic               dclk_s;
  logic               accept_s;
  logic               sel_change_s;
  logic [DWELL_W-1:0] dwell_tgt_s;
  logic               dwell_hit_s;

  assign ratio_s     = sel_to_ratio(cur_sel_q);
  assign req_ready   = (state_q == ST_RUN);
  assign accept_s    = req_valid && (state_q == ST_RUN);
  assign dwell_tgt_s = (dwell == {DWELL_W{1'b0}}) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell;
  // >= rather than == so a dwell lowered mid-count still steps at the next boundary.
  assign dwell_hit_s = ({1'b0, dwell_cnt_q} + {{DWELL_W{1'b0}}, 1'b1}) >= {1'b0, dwell_tgt_s};
  assign sel_change_s = period_end_s && (cur_sel_d != cur_sel_q);

  div_period_counter u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .ratio_i      (ratio_s),
    .load_zero_i  (sel_change_s),
    .cnt_o        (cnt_s),
    .dclk_o       (dclk_s),
    .period_end_o (period_end_s)
  );

  assign dclk       = dclk_s;
  assign period_end = period_end_s;
  assign cur_sel    = cur_sel_q;
  assign switched   = switched_q;

  // Next-state: a pending request wins the boundary over an auto step.
  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    pend_sel_d  = pend_sel_q;
    dwell_cnt_d = dwell_cnt_q;
    case (state_q)
      ST_PEND: begin
        if (period_end_s) begin
          cur_sel_d   = pend_sel_q;
          dwell_cnt_d = {DWELL_W{1'b0}};
          state_d     = ST_RUN;
        end else if (!auto_en) begin
          dwell_cnt_d = {DWELL_W{1'b0}};
        end else begin
          dwell_cnt_d = dwell_cnt_q;
        end
      end
      ST_RUN: begin
        if (!auto_en) begin
          dwell_cnt_d = {DWELL_W{1'b0}};
        end else if (period_end_s && dwell_hit_s) begin
          cur_sel_d   = next_auto_sel(cur_sel_q);
          dwell_cnt_d = {DWELL_W{1'b0}};
        end else if (period_end_s) begin
          dwell_cnt_d = dwell_cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
          dwell_cnt_d = dwell_cnt_q;
        end
        if (accept_s) begin
          state_d    = ST_PEND;
          pend_sel_d = req_sel;
        end else begin
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d     = ST_RUN;
        dwell_cnt_d = {DWELL_W{1'b0}};
      end
    endcase
    switched_d = sel_change_s;
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cur_sel_q   <= RST_SEL;
      pend_sel_q  <= 2'd0;
      dwell_cnt_q <= {DWELL_W{1'b0}};
      switched_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      dwell_cnt_q <= dwell_cnt_d;
      switched_q  <= switched_d;
    end
  end

endmodule
